// File: rtl/setpoint_entry_if.sv
// setpoint_entry_if: button inputs, edit enable and setpoint outputs of the setpoint front end
interface setpoint_entry_if #(parameter int TEMP_W = 10);
  logic button1, button2, set_en;
  logic [TEMP_W-1:0] goal_temp;
  logic inc_pulse, dec_pulse, at_limit;
  modport master(output button1, button2, set_en, input goal_temp, inc_pulse, dec_pulse, at_limit);
  modport slave(input button1, button2, set_en, output goal_temp, inc_pulse, dec_pulse, at_limit);
endinterface

// File: rtl/setpoint_entry.sv
// setpoint_entry: debounced inc/dec buttons with auto-repeat driving a saturating setpoint register
// Define SETPOINT_ACCEL_EN to quadruple the step after 8 consecutive auto-repeat steps.
module setpoint_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE = 5000000,
  parameter int STEP = 5,
  parameter int MIN_TEMP = 150,
  parameter int MAX_TEMP = 550,
  parameter int INIT_TEMP = 300,
  parameter int TEMP_W = 10
) (
  input logic clk,
  input logic rst,
  setpoint_entry_if.slave sif
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
  localparam logic [TEMP_W:0] MAX_X = (TEMP_W+1)'(MAX_TEMP);
  localparam logic [TEMP_W:0] MIN_X = (TEMP_W+1)'(MIN_TEMP);
  localparam logic [TEMP_W:0] STEP_X = (TEMP_W+1)'(STEP);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  logic [1:0] s1, s2, deb, req;
  logic [DW-1:0] dcnt [2];
  state_t st [2];
  state_t st_n [2];
  logic [TW-1:0] tmr [2];
  logic [TW-1:0] tmr_n [2];
  logic lock, blocked;
  logic [TEMP_W-1:0] goal, up_val, dn_val;
  logic [TEMP_W:0] up_amt, dn_amt, up_sum, dn_floor;
  // index 0 is the increment button, index 1 the decrement button
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 2'b11;
      s2 <= 2'b11;
      deb <= 2'b11;
      lock <= 1'b0;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      s1 <= {sif.button2, sif.button1};
      s2 <= s1;
      lock <= deb == 2'b00 ? 1'b1 : deb == 2'b11 ? 1'b0 : lock;
      for (int i = 0; i < 2; i++)
        if (s2[i] == deb[i]) dcnt[i] <= '0;
        else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= s2[i];
          dcnt[i] <= '0;
        end else dcnt[i] <= dcnt[i] + 1'b1;
    end
  // a chord locks both buttons out until both are released again
  assign blocked = lock | (deb == 2'b00);
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_n[i] = IDLE;
      tmr_n[i] = '0;
      req[i] = 1'b0;
      if (!deb[i] && !blocked)
        case (st[i])
          IDLE: begin
            st_n[i] = HOLD;
            req[i] = 1'b1;
          end
          HOLD: begin
            req[i] = tmr[i] == TW'(REPEAT_DELAY - 1);
            st_n[i] = req[i] ? REPEAT : HOLD;
            tmr_n[i] = req[i] ? '0 : tmr[i] + 1'b1;
          end
          default: begin
            req[i] = tmr[i] == TW'(REPEAT_RATE - 1);
            st_n[i] = REPEAT;
            tmr_n[i] = req[i] ? '0 : tmr[i] + 1'b1;
          end
        endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < 2; i++) begin
        st[i] <= IDLE;
        tmr[i] <= '0;
      end
    else
      for (int i = 0; i < 2; i++) begin
        st[i] <= st_n[i];
        tmr[i] <= tmr_n[i];
      end
`ifdef SETPOINT_ACCEL_EN
  logic [3:0] run [2];
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < 2; i++) run[i] <= '0;
    else
      for (int i = 0; i < 2; i++)
        if (deb[i] || blocked) run[i] <= '0;
        else if (req[i] && st[i] != IDLE && run[i] != 4'd8) run[i] <= run[i] + 1'b1;
  assign up_amt = run[0] == 4'd8 ? (TEMP_W+1)'(4 * STEP) : STEP_X;
  assign dn_amt = run[1] == 4'd8 ? (TEMP_W+1)'(4 * STEP) : STEP_X;
`else
  assign up_amt = STEP_X;
  assign dn_amt = STEP_X;
`endif
  assign up_sum = {1'b0, goal} + up_amt;
  assign dn_floor = MIN_X + dn_amt;
  assign up_val = up_sum > MAX_X ? MAX_X[TEMP_W-1:0] : up_sum[TEMP_W-1:0];
  assign dn_val = {1'b0, goal} < dn_floor ? MIN_X[TEMP_W-1:0] : goal - dn_amt[TEMP_W-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      goal <= TEMP_W'(INIT_TEMP);
      sif.inc_pulse <= 1'b0;
      sif.dec_pulse <= 1'b0;
    end else begin
      sif.inc_pulse <= req[0] & sif.set_en;
      sif.dec_pulse <= req[1] & sif.set_en;
      if (req[0] && sif.set_en) goal <= up_val;
      else if (req[1] && sif.set_en) goal <= dn_val;
    end
  assign sif.goal_temp = goal;
  assign sif.at_limit = goal == MIN_X[TEMP_W-1:0] || goal == MAX_X[TEMP_W-1:0];
endmodule

// File: tb/tb_setpoint_entry.sv
// tb_setpoint_entry: scoreboard bench for button conditioning, auto-repeat, chord lockout and saturation
module tb_setpoint_entry;
  localparam int DB = 4, RD = 20, RR = 5, STEP = 5, MIN = 150, MAX = 550, INIT = 300;
`ifdef SETPOINT_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  setpoint_entry_if #(.TEMP_W(10)) sif();
  setpoint_entry #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .STEP(STEP),
    .MIN_TEMP(MIN), .MAX_TEMP(MAX), .INIT_TEMP(INIT), .TEMP_W(10))
    dut (.clk(clk), .rst(rst), .sif(sif));
  typedef struct packed {logic inc; logic [9:0] goal;} exp_t;
  exp_t exp_q[$];
  int pulse_cyc[$];
  int n_cmp = 0, n_bad = 0, n_inc = 0, n_dec = 0, cyc = 0, model = INIT, run_idx = 0;

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (sif.inc_pulse || sif.dec_pulse) begin
      pulse_cyc.push_back(cyc);
      n_inc += int'(sif.inc_pulse);
      n_dec += int'(sif.dec_pulse);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: inc=%0b dec=%0b goal=%0d, required no pulse", sif.inc_pulse, sif.dec_pulse, sif.goal_temp);
      end else begin
        e = exp_q.pop_front();
        if ({sif.inc_pulse, sif.dec_pulse, sif.goal_temp} !== {e.inc, ~e.inc, e.goal}) begin
          n_bad++;
          $display("FAIL sb_step: got inc=%0b dec=%0b goal=%0d, required inc=%0b dec=%0b goal=%0d",
            sif.inc_pulse, sif.dec_pulse, sif.goal_temp, e.inc, ~e.inc, e.goal);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_step(input bit inc);
    exp_t e;
    int amt;
    amt = (ACCEL && run_idx >= 9) ? 4 * STEP : STEP;
    model = inc ? (model + amt > MAX ? MAX : model + amt) : (model - amt < MIN ? MIN : model - amt);
    e.inc = inc;
    e.goal = 10'(model);
    exp_q.push_back(e);
    run_idx++;
  endtask

  task automatic wait_pulses(input int total, input int budget);
    int b;
    b = 0;
    while (n_inc + n_dec < total && b < budget) begin
      tick();
      b++;
    end
    if (n_inc + n_dec < total) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_timeout: got %0d pulses, required %0d", n_inc + n_dec, total);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sif.button1 = 1'b1;
    sif.button2 = 1'b1;
    sif.set_en = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    model = INIT;
    run_idx = 0;
    exp_q.delete();
    pulse_cyc.delete();
    n_inc = 0;
    n_dec = 0;
  endtask

  task automatic test_reset();
    sif.button1 = 1'b1;
    sif.button2 = 1'b1;
    sif.set_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({sif.goal_temp, sif.inc_pulse, sif.dec_pulse, sif.at_limit} !== {10'd300, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_state: got goal=%0d inc=%0b dec=%0b lim=%0b, required 300 0 0 0",
        sif.goal_temp, sif.inc_pulse, sif.dec_pulse, sif.at_limit);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_press();
    do_reset();
    push_step(1'b1);
    sif.button1 = 1'b0;
    repeat (10) tick();
    sif.button1 = 1'b1;
    repeat (30) tick();
    n_cmp++;
    if (n_inc !== 1 || n_dec !== 0 || sif.goal_temp !== 10'd305 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL single_press: got inc=%0d dec=%0d goal=%0d, required 1 0 305", n_inc, n_dec, sif.goal_temp);
    end
  endtask

  task automatic test_chatter();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      sif.button1 = ((k / 2) % 2) != 0;
      tick();
    end
    sif.button1 = 1'b1;
    repeat (20) tick();
    n_cmp++;
    if (n_inc !== 0 || sif.goal_temp !== 10'd300) begin
      n_bad++;
      $display("FAIL chatter: got inc=%0d goal=%0d, required 0 300", n_inc, sif.goal_temp);
    end
  endtask

  task automatic test_repeat();
    do_reset();
    repeat (9) push_step(1'b0);
    sif.button2 = 1'b0;
    repeat (60) tick();
    sif.button2 = 1'b1;
    repeat (20) tick();
    n_cmp++;
    if (n_dec !== 9 || n_inc !== 0 || sif.goal_temp !== 10'd255 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL repeat_count: got dec=%0d inc=%0d goal=%0d, required 9 0 255", n_dec, n_inc, sif.goal_temp);
    end
    if (pulse_cyc.size() == 9)
      for (int k = 1; k < 9; k++) begin
        n_cmp++;
        if (pulse_cyc[k] - pulse_cyc[k-1] != (k == 1 ? RD : RR)) begin
          n_bad++;
          $display("FAIL repeat_gap%0d: got %0d cycles, required %0d", k, pulse_cyc[k] - pulse_cyc[k-1], k == 1 ? RD : RR);
        end
      end
  endtask

  task automatic test_saturation(input bit inc);
    int n, lim;
    do_reset();
    lim = inc ? MAX : MIN;
    n = 0;
    while (model != lim) begin
      push_step(inc);
      n++;
    end
    push_step(inc);
    push_step(inc);
    n += 2;
    if (inc) sif.button1 = 1'b0;
    else sif.button2 = 1'b0;
    wait_pulses(n, 600);
    sif.set_en = 1'b0;
    sif.button1 = 1'b1;
    sif.button2 = 1'b1;
    repeat (20) tick();
    n_cmp++;
    if (sif.goal_temp !== 10'(lim) || sif.at_limit !== 1'b1 || exp_q.size() != 0 || n_inc + n_dec != n) begin
      n_bad++;
      $display("FAIL saturate_%s: got goal=%0d lim=%0b pulses=%0d, required %0d 1 %0d",
        inc ? "max" : "min", sif.goal_temp, sif.at_limit, n_inc + n_dec, lim, n);
    end
    sif.set_en = 1'b1;
  endtask

  task automatic test_chord();
    do_reset();
    sif.button1 = 1'b0;
    sif.button2 = 1'b0;
    repeat (30) tick();
    sif.button2 = 1'b1;
    repeat (30) tick();
    sif.button1 = 1'b1;
    repeat (20) tick();
    n_cmp++;
    if (n_inc !== 0 || n_dec !== 0 || sif.goal_temp !== 10'd300) begin
      n_bad++;
      $display("FAIL chord_lockout: got inc=%0d dec=%0d goal=%0d, required 0 0 300", n_inc, n_dec, sif.goal_temp);
    end
    push_step(1'b1);
    sif.button1 = 1'b0;
    repeat (10) tick();
    sif.button1 = 1'b1;
    repeat (20) tick();
    n_cmp++;
    if (n_inc !== 1 || sif.goal_temp !== 10'd305 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL chord_repress: got inc=%0d goal=%0d, required 1 305", n_inc, sif.goal_temp);
    end
  endtask

  task automatic test_set_en_off();
    do_reset();
    sif.set_en = 1'b0;
    sif.button1 = 1'b0;
    repeat (40) tick();
    sif.button1 = 1'b1;
    repeat (15) tick();
    sif.button2 = 1'b0;
    repeat (40) tick();
    sif.button2 = 1'b1;
    repeat (15) tick();
    n_cmp++;
    if (n_inc !== 0 || n_dec !== 0 || sif.goal_temp !== 10'd300) begin
      n_bad++;
      $display("FAIL set_en_off: got inc=%0d dec=%0d goal=%0d, required 0 0 300", n_inc, n_dec, sif.goal_temp);
    end
    sif.set_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int c0;
    do_reset();
    repeat (12) push_step(1'b1);
    sif.button1 = 1'b0;
    wait_pulses(12, 200);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({sif.goal_temp, sif.inc_pulse, sif.dec_pulse, sif.at_limit} !== {10'd300, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_mid: got goal=%0d inc=%0b dec=%0b lim=%0b, required 300 0 0 0",
        sif.goal_temp, sif.inc_pulse, sif.dec_pulse, sif.at_limit);
    end
    repeat (3) tick();
    rst = 1'b0;
    model = INIT;
    run_idx = 0;
    exp_q.delete();
    pulse_cyc.delete();
    n_inc = 0;
    c0 = cyc;
    push_step(1'b1);
    wait_pulses(1, 20);
    sif.button1 = 1'b1;
    repeat (20) tick();
    n_cmp++;
    if (n_inc !== 1 || sif.goal_temp !== 10'd305 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL reset_mid_step: got inc=%0d goal=%0d, required 1 305", n_inc, sif.goal_temp);
    end
    n_cmp++;
    if (pulse_cyc.size() == 0 || pulse_cyc[0] - c0 < DB + 2) begin
      n_bad++;
      $display("FAIL reset_mid_latency: got %0d cycles, required at least %0d", pulse_cyc.size() == 0 ? -1 : pulse_cyc[0] - c0, DB + 2);
    end
  endtask

`ifdef SETPOINT_ACCEL_EN
  task automatic test_accel();
    do_reset();
    repeat (12) push_step(1'b1);
    sif.button1 = 1'b0;
    wait_pulses(12, 200);
    sif.set_en = 1'b0;
    sif.button1 = 1'b1;
    repeat (20) tick();
    sif.set_en = 1'b1;
    n_cmp++;
    if (sif.goal_temp !== 10'd405 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL accel: got goal=%0d, required 405", sif.goal_temp);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_chatter();
    test_repeat();
    test_saturation(1'b1);
    test_saturation(1'b0);
    test_chord();
    test_set_en_off();
    test_reset_mid();
`ifdef SETPOINT_ACCEL_EN
    test_accel();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/setpoint_entry.md
Name: setpoint_entry

Overview:
- Front end for the oven setpoint: conditions the two raw active-low push buttons and owns the goal-temperature register.
- Synchronises and debounces both buttons, then issues one step on each press and auto-repeats while a button is held.
- Saturates the setpoint at configured limits.
- Drives goal_temp to the temperature controller and the BCD/hex display path.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable samples needed to accept a level change (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000: cycles a button is held after the first step before auto-repeat starts.
- REPEAT_RATE, 5000000: cycles between auto-repeat steps.
- STEP, 5: degrees per step.
- MIN_TEMP, 150: lower saturation limit.
- MAX_TEMP, 550: upper saturation limit.
- INIT_TEMP, 300: goal_temp value after reset.
- TEMP_W, 10: width of goal_temp.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- button1  in  1  raw increment button, active-low.
- button2  in  1  raw decrement button, active-low.
- set_en  in  1  high = setpoint editing allowed.
- goal_temp  out  TEMP_W  current setpoint, registered.
- inc_pulse  out  1  one-cycle strobe on each accepted increment.
- dec_pulse  out  1  one-cycle strobe on each accepted decrement.
- at_limit  out  1  high while goal_temp equals MIN_TEMP or MAX_TEMP.

Behaviour:
- Reset (async assert, sync release):
  - goal_temp = INIT_TEMP; inc_pulse = dec_pulse = 0; at_limit = (INIT_TEMP == MIN_TEMP or INIT_TEMP == MAX_TEMP).
  - Synchronisers and debounced levels = released (1); all counters 0; both FSMs in IDLE.
- Synchronisation: two-flop synchroniser per button. The raw inputs reach no other logic.
- Debounce (per button):
  - Counter clears whenever the synchronised sample equals the debounced level.
  - Otherwise the counter increments; on reaching DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
- Per-button FSM, states IDLE, HOLD, REPEAT:
  - IDLE -> HOLD on debounced press; one step requested that cycle.
  - HOLD: counts REPEAT_DELAY cycles, then -> REPEAT with one step requested.
  - REPEAT: one step requested every REPEAT_RATE cycles.
  - Debounced release in any state -> IDLE, counters cleared.
- Chord (both debounced pressed in the same cycle):
  - Both FSMs go to IDLE and all steps are suppressed.
  - Lockout holds until both buttons are debounced released; a button still held after the other is released produces no step.
- Step application:
  - A step request with set_en=1 updates goal_temp on the same edge that asserts the matching pulse (both registered, one-cycle wide).
  - With set_en=0, requests are dropped, not queued, and FSMs keep tracking.
- Arithmetic, computed at TEMP_W+1 bits to avoid wrap:
  - Increment: goal_temp = min(goal_temp+STEP, MAX_TEMP).
  - Decrement: goal_temp = max(goal_temp-STEP, MIN_TEMP); no underflow below MIN_TEMP.
  - A step at a limit leaves the value unchanged but still asserts its pulse.
- at_limit is combinational from goal_temp.
- Reset mid-press: a button held through reset release must re-debounce, then produce a fresh first step.

Optional Feature:
- Macro SETPOINT_ACCEL_EN.
- Defined: after 8 consecutive REPEAT-state steps on one button, the step size becomes 4*STEP, still saturated. The run count clears on release or chord.
- Undefined: step size is always STEP; no run counter is synthesised.

Test Plan (bench overrides: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, STEP=5, MIN_TEMP=150, MAX_TEMP=550, INIT_TEMP=300):
- Reset, button1 held low 10 cycles then released, set_en=1 -> exactly one inc_pulse; goal_temp 300->305, no repeat.
- button1 chatters (toggles every 2 cycles for 12 cycles), then stable high -> no pulse; goal_temp stays 300.
- button2 held 60 cycles -> first step, repeats 20 and 25 cycles after it, then every 5; 300 decreases by 5 per dec_pulse; count pulses against the schedule.
- goal_temp at 545, button1 held into repeat -> 550, then pulses continue with 550 unchanged; at_limit=1. Mirror case at 150 with no underflow.
- Both buttons pressed same cycle, button2 released while button1 held -> zero pulses until both released and re-pressed. With set_en=0, presses yield no pulses and no change.
- Assert rst while button1 held mid-REPEAT -> outputs return to reset values immediately. After release of rst, with button1 still held, one new step arrives after the debounce delay (goal 305).
- With SETPOINT_ACCEL_EN defined: button1 held from 300 -> steps of 5 until 8 repeat steps, then 20 per step, saturating at 550.
